// File: rtl/pin_entry_ctrl.sv
// Keypad PIN lock controller: collects four digits, compares against a stored
// PIN, and handles auto-relock, PIN change while open and failed-attempt lockout.
module pin_entry_ctrl #(
  parameter logic [15:0] DEFAULT_PIN   = 16'h1234,
  parameter int          MAX_FAILS     = 3,
  parameter int          ENTRY_TIMEOUT = 5000,
  parameter int          RELOCK_TICKS  = 2500,
  parameter int          LOCKOUT_TICKS = 5000
) (
  input  logic       clk_500Hz,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] pin0,
  output logic [3:0] pin1,
  output logic [3:0] pin2,
  output logic [3:0] pin3,
  output logic       status,
  output logic       lockout,
  output logic       tone_ok,
  output logic       tone_bad
);

  localparam logic [2:0] ST_LOCKED    = 3'd0;
  localparam logic [2:0] ST_ENTRY     = 3'd1;
  localparam logic [2:0] ST_UNLOCKED  = 3'd2;
  localparam logic [2:0] ST_SET_ENTRY = 3'd3;
  localparam logic [2:0] ST_LOCKOUT   = 3'd4;

  localparam logic [15:0] SLOTS_EMPTY = 16'hFFFF;
  localparam logic [15:0] ENTRY_LIM   = 16'(ENTRY_TIMEOUT - 1);
  localparam logic [15:0] RELOCK_LIM  = 16'(RELOCK_TICKS - 1);
  localparam logic [15:0] LOCKOUT_LIM = 16'(LOCKOUT_TICKS - 1);
  localparam logic [1:0]  FAIL_LIM    = 2'(MAX_FAILS);

  logic [2:0]  state_q, state_d;
  logic [15:0] slots_q, slots_d;
  logic [15:0] stored_q, stored_d;
  logic [1:0]  fail_q, fail_d;
  logic [15:0] timer_q, timer_d;
  logic        status_q, status_d;
  logic        lockout_q, lockout_d;
  logic        tone_ok_q, tone_ok_d;
  logic        tone_bad_q, tone_bad_d;

  logic        accept_s;
  logic        is_digit_s, is_enter_s, is_clear_s, is_lock_s, is_set_s;
  logic        full_s;
  logic [1:0]  fail_inc_s;

  // Slot 15 marks empty; digits land in the lowest-index empty slot.
  function automatic logic [15:0] fill_slot(input logic [15:0] s, input logic [3:0] d);
    logic [15:0] r;
    r = s;
    if (s[15:12] == 4'hF) begin
      r[15:12] = d;
    end else if (s[11:8] == 4'hF) begin
      r[11:8] = d;
    end else if (s[7:4] == 4'hF) begin
      r[7:4] = d;
    end else if (s[3:0] == 4'hF) begin
      r[3:0] = d;
    end else begin
      r = s;
    end
    return r;
  endfunction

  function automatic logic slots_full(input logic [15:0] s);
    return (s[15:12] != 4'hF) && (s[11:8] != 4'hF) && (s[7:4] != 4'hF) && (s[3:0] != 4'hF);
  endfunction

  // Next-state logic: an accepted key always takes priority over a timeout.
  always_comb begin
    is_digit_s = key_valid && (key_code <= 4'd9);
    is_enter_s = key_valid && (key_code == 4'd10);
    is_clear_s = key_valid && (key_code == 4'd11);
    is_lock_s  = key_valid && (key_code == 4'd12);
    is_set_s   = key_valid && (key_code == 4'd13);
    full_s     = slots_full(slots_q);
    fail_inc_s = fail_q + 2'd1;

    state_d    = state_q;
    slots_d    = slots_q;
    stored_d   = stored_q;
    fail_d     = fail_q;
    tone_ok_d  = 1'b0;
    tone_bad_d = 1'b0;
    accept_s   = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (is_digit_s) begin
          accept_s = 1'b1;
          slots_d  = fill_slot(SLOTS_EMPTY, key_code);
          state_d  = ST_ENTRY;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_ENTRY: begin
        if (is_digit_s && !full_s) begin
          accept_s = 1'b1;
          slots_d  = fill_slot(slots_q, key_code);
        end else if (is_clear_s) begin
          accept_s = 1'b1;
          slots_d  = SLOTS_EMPTY;
          state_d  = ST_LOCKED;
        end else if (is_enter_s && full_s) begin
          accept_s = 1'b1;
          slots_d  = SLOTS_EMPTY;
          if (slots_q == stored_q) begin
            fail_d    = 2'd0;
            tone_ok_d = 1'b1;
            state_d   = ST_UNLOCKED;
          end else if (fail_inc_s == FAIL_LIM) begin
            fail_d     = 2'd0;
            tone_bad_d = 1'b1;
            state_d    = ST_LOCKOUT;
          end else begin
            fail_d     = fail_inc_s;
            tone_bad_d = 1'b1;
            state_d    = ST_LOCKED;
          end
        end else if (timer_q == ENTRY_LIM) begin
          slots_d = SLOTS_EMPTY;
          state_d = ST_LOCKED;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_UNLOCKED: begin
        if (is_lock_s) begin
          accept_s = 1'b1;
          state_d  = ST_LOCKED;
        end else if (is_set_s) begin
          accept_s = 1'b1;
          state_d  = ST_SET_ENTRY;
        end else if (is_digit_s || is_enter_s || is_clear_s) begin
          accept_s = 1'b1;
        end else if (timer_q == RELOCK_LIM) begin
          state_d = ST_LOCKED;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_SET_ENTRY: begin
        if (is_digit_s && !full_s) begin
          accept_s = 1'b1;
          slots_d  = fill_slot(slots_q, key_code);
        end else if (is_enter_s && full_s) begin
          accept_s  = 1'b1;
          stored_d  = slots_q;
          slots_d   = SLOTS_EMPTY;
          tone_ok_d = 1'b1;
          state_d   = ST_UNLOCKED;
        end else if (is_clear_s) begin
          accept_s = 1'b1;
          slots_d  = SLOTS_EMPTY;
          state_d  = ST_UNLOCKED;
        end else if (is_lock_s) begin
          accept_s = 1'b1;
          slots_d  = SLOTS_EMPTY;
          state_d  = ST_LOCKED;
        end else if (timer_q == ENTRY_LIM) begin
          slots_d = SLOTS_EMPTY;
          state_d = ST_UNLOCKED;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCKOUT_LIM) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: begin
        state_d = ST_LOCKED;
        slots_d = SLOTS_EMPTY;
      end
    endcase

    timer_d   = (accept_s || (state_d != state_q)) ? 16'd0 : timer_q + 16'd1;
    status_d  = (state_d == ST_UNLOCKED) || (state_d == ST_SET_ENTRY);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOCKED;
      slots_q    <= SLOTS_EMPTY;
      stored_q   <= DEFAULT_PIN;
      fail_q     <= 2'd0;
      timer_q    <= 16'd0;
      status_q   <= 1'b0;
      lockout_q  <= 1'b0;
      tone_ok_q  <= 1'b0;
      tone_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slots_q    <= slots_d;
      stored_q   <= stored_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      status_q   <= status_d;
      lockout_q  <= lockout_d;
      tone_ok_q  <= tone_ok_d;
      tone_bad_q <= tone_bad_d;
    end
  end

  assign pin0     = slots_q[15:12];
  assign pin1     = slots_q[11:8];
  assign pin2     = slots_q[7:4];
  assign pin3     = slots_q[3:0];
  assign status   = status_q;
  assign lockout  = lockout_q;
  assign tone_ok  = tone_ok_q;
  assign tone_bad = tone_bad_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed self-checking bench for pin_entry_ctrl; inputs change and outputs
// are sampled on the falling clock edge.
module tb_pin_entry_ctrl;

  logic       clk_500Hz;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] pin0, pin1, pin2, pin3;
  logic       status, lockout, tone_ok, tone_bad;
  logic [15:0] pins_s;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] K_ENTER = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [3:0] K_LOCK  = 4'd12;
  localparam logic [3:0] K_SET   = 4'd13;

  pin_entry_ctrl dut (
    .clk_500Hz(clk_500Hz),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .pin0     (pin0),
    .pin1     (pin1),
    .pin2     (pin2),
    .pin3     (pin3),
    .status   (status),
    .lockout  (lockout),
    .tone_ok  (tone_ok),
    .tone_bad (tone_bad)
  );

  assign pins_s = {pin0, pin1, pin2, pin3};

  initial clk_500Hz = 1'b0;
  always #5 clk_500Hz = ~clk_500Hz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the key is sampled on the next rising edge.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk_500Hz);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_500Hz);
  endtask

  task automatic enter_pin(input logic [15:0] p);
    press(p[15:12]);
    press(p[11:8]);
    press(p[7:4]);
    press(p[3:0]);
    press(K_ENTER);
  endtask

  initial begin
    rst = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_pins", 32'(pins_s), 32'hFFFF);
    check_eq("rst_status", 32'(status), 32'd0);
    check_eq("rst_lockout", 32'(lockout), 32'd0);
    check_eq("rst_tones", 32'({tone_ok, tone_bad}), 32'd0);
    @(negedge clk_500Hz);
    rst = 1'b0;

    // Default PIN unlock with slot fill order
    press(4'd1); check_eq("fill1", 32'(pins_s), 32'h1FFF);
    press(4'd2); check_eq("fill2", 32'(pins_s), 32'h12FF);
    press(4'd3); check_eq("fill3", 32'(pins_s), 32'h123F);
    press(4'd4); check_eq("fill4", 32'(pins_s), 32'h1234);
    press(K_ENTER);
    check_eq("unlock_status", 32'(status), 32'd1);
    check_eq("unlock_tone_ok", 32'(tone_ok), 32'd1);
    check_eq("unlock_tone_bad", 32'(tone_bad), 32'd0);
    check_eq("unlock_pins", 32'(pins_s), 32'hFFFF);
    idle(1);
    check_eq("tone_ok_one_cycle", 32'(tone_ok), 32'd0);

    // Auto-relock; ENTER on the relock edge restarts the count
    idle(2498);
    check_eq("relock_2499", 32'(status), 32'd1);
    press(K_ENTER);
    check_eq("relock_key_wins", 32'(status), 32'd1);
    idle(2499);
    check_eq("relock_restart_2499", 32'(status), 32'd1);
    idle(1);
    check_eq("relock_2500", 32'(status), 32'd0);

    // Three wrong PINs -> lockout
    enter_pin(16'h9999);
    check_eq("bad1_tone", 32'(tone_bad), 32'd1);
    check_eq("bad1_lockout", 32'(lockout), 32'd0);
    enter_pin(16'h9999);
    check_eq("bad2_tone", 32'(tone_bad), 32'd1);
    enter_pin(16'h9999);
    check_eq("bad3_tone", 32'(tone_bad), 32'd1);
    check_eq("bad3_lockout", 32'(lockout), 32'd1);
    press(4'd1);
    press(K_ENTER);
    check_eq("lockout_ignores_keys", 32'(pins_s), 32'hFFFF);
    idle(4997);
    check_eq("lockout_4999", 32'(lockout), 32'd1);
    idle(1);
    check_eq("lockout_5000", 32'(lockout), 32'd0);
    check_eq("lockout_exit_status", 32'(status), 32'd0);
    press(4'd1);
    check_eq("locked_after_lockout", 32'(pins_s), 32'h1FFF);
    press(K_CLEAR);
    check_eq("clear_pins", 32'(pins_s), 32'hFFFF);

    // PIN change to 5678
    enter_pin(16'h1234);
    press(K_SET);
    check_eq("set_status", 32'(status), 32'd1);
    press(4'd5); press(4'd6); press(4'd7); press(4'd8);
    check_eq("set_slots", 32'(pins_s), 32'h5678);
    press(K_ENTER);
    check_eq("set_tone_ok", 32'(tone_ok), 32'd1);
    check_eq("set_done_pins", 32'(pins_s), 32'hFFFF);
    press(K_SET);
    press(4'd9);
    press(K_CLEAR);
    check_eq("set_clear_status", 32'(status), 32'd1);
    check_eq("set_clear_pins", 32'(pins_s), 32'hFFFF);
    press(K_LOCK);
    check_eq("lock_status", 32'(status), 32'd0);
    enter_pin(16'h1234);
    check_eq("old_pin_bad", 32'(tone_bad), 32'd1);
    check_eq("old_pin_status", 32'(status), 32'd0);
    enter_pin(16'h5678);
    check_eq("new_pin_status", 32'(status), 32'd1);
    check_eq("new_pin_tone_ok", 32'(tone_ok), 32'd1);
    press(K_LOCK);

    // Entry timeout; key on the timeout edge wins
    press(4'd3); press(4'd7);
    idle(4999);
    check_eq("timeout_4999", 32'(pins_s), 32'h37FF);
    idle(1);
    check_eq("timeout_5000", 32'(pins_s), 32'hFFFF);
    press(4'd3); press(4'd7);
    idle(4999);
    press(4'd5);
    check_eq("timeout_key_wins", 32'(pins_s), 32'h375F);
    press(K_CLEAR);

    // Fifth digit ignored; short ENTER ignored
    press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'd9);
    check_eq("fifth_ignored", 32'(pins_s), 32'h5678);
    press(K_ENTER);
    check_eq("fifth_unlock", 32'(status), 32'd1);
    press(K_LOCK);
    press(4'd1); press(4'd2); press(K_ENTER);
    check_eq("short_enter_pins", 32'(pins_s), 32'h12FF);
    check_eq("short_enter_tones", 32'({tone_ok, tone_bad}), 32'd0);
    check_eq("short_enter_status", 32'(status), 32'd0);

    // Asynchronous reset mid-entry restores DEFAULT_PIN
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_pins", 32'(pins_s), 32'hFFFF);
    check_eq("async_rst_status", 32'(status), 32'd0);
    @(negedge clk_500Hz);
    rst = 1'b0;
    enter_pin(16'h1234);
    check_eq("default_reloaded", 32'(status), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
